// File: rtl/syn_fifo_fwft.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// occupancy count, programmable almost flags and overflow/underflow pulses.
module syn_fifo_fwft #(
  parameter int unsigned DSIZE         = 32,
  parameter int unsigned ASIZE         = 9,
  parameter string       RAM_TYPE      = "block",
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = (1 << ASIZE) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE + 1)'(AFULL_THRESH);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE + 1)'(AEMPTY_THRESH);
  localparam logic [ASIZE:0] ONE_C    = (ASIZE + 1)'(1);

  (* ram_style = RAM_TYPE *) logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr_q, rptr_q;
  logic [ASIZE:0] count_q, count_d;
  logic           overflow_q, underflow_q;
  logic           wacc;          // write accepted this cycle
  logic           pop;           // a word leaves the FIFO (count decrements)
  logic           mem_rd;        // a word is read out of storage (rptr advances)
  logic           mem_has_data;  // storage itself (not output stages) holds words

  assign wfull         = (count_q == DEPTH_C);
  assign walmost_full  = (count_q >= AFULL_C);
  assign ralmost_empty = (count_q <= AEMPTY_C);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  assign wacc         = winc && !wfull;
  assign mem_has_data = (wptr_q != rptr_q);

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({wacc, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wacc) mem[wptr_q[ASIZE-1:0]] <= wdata;
  end

  // Pointers, occupancy and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wacc)   wptr_q <= wptr_q + ONE_C;
      if (mem_rd) rptr_q <= rptr_q + ONE_C;
      count_q     <= count_d;
      overflow_q  <= winc && wfull;
      underflow_q <= rinc && rempty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Two-stage prefetch: stage_q is the synchronous RAM read register,
    // out_q presents the head word. Both count toward occupancy.
    logic [DSIZE-1:0] stage_q, out_q;
    logic             stage_vld_q, out_vld_q;
    logic             out_load, fetch;

    assign pop      = rinc && out_vld_q;
    assign out_load = stage_vld_q && (!out_vld_q || pop);
    assign fetch    = mem_has_data && (!stage_vld_q || out_load);
    assign mem_rd   = fetch;
    assign rempty   = !out_vld_q;
    assign rdata    = out_q;

    // RAM read register, kept reset-free so it maps onto the BRAM output latch.
    always_ff @(posedge clk) begin
      if (fetch) stage_q <= mem[rptr_q[ASIZE-1:0]];
    end

    // Valid tracking for both stages and the presented head word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_vld_q <= 1'b0;
        out_vld_q   <= 1'b0;
        out_q       <= '0;
      end else begin
        if (fetch)         stage_vld_q <= 1'b1;
        else if (out_load) stage_vld_q <= 1'b0;
        if (out_load) begin
          out_q     <= stage_q;
          out_vld_q <= 1'b1;
        end else if (pop) begin
          out_vld_q <= 1'b0;
        end
      end
    end
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    // With no output stages, storage non-empty is equivalent to count != 0.
    assign pop    = rinc && mem_has_data;
    assign mem_rd = pop;
    assign rempty = (count_q == '0);
    assign rdata  = rdata_q;

    // Registered read: rdata changes only on an accepted read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      rdata_q <= '0;
      else if (pop) rdata_q <= mem[rptr_q[ASIZE-1:0]];
    end
  end

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// Bench for syn_fifo_fwft: a standard-mode and an FWFT-mode instance run in
// lockstep on the same stimulus, each checked against a queue-based model.
module tb_syn_fifo_fwft;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            wr;    // edge index at which the word was written
  } fent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;

  logic [DW-1:0] s_rdata, f_rdata;
  logic [AW:0]   s_count, f_count;
  logic s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_udf;
  logic f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_udf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [DW-1:0] sq[$];
  logic [DW-1:0] s_rd_m = '0;
  fent_t         fq[$];

  always #5 clk = ~clk;

  syn_fifo_fwft #(
    .DSIZE(DW), .ASIZE(AW), .RAM_TYPE("block"), .FWFT(0),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut_std (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(s_wfull),
    .walmost_full(s_afull), .rinc(rinc), .rdata(s_rdata), .rempty(s_rempty),
    .ralmost_empty(s_aempty), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  syn_fifo_fwft #(
    .DSIZE(DW), .ASIZE(AW), .RAM_TYPE("block"), .FWFT(1),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(f_wfull),
    .walmost_full(f_afull), .rinc(rinc), .rdata(f_rdata), .rempty(f_rempty),
    .ralmost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("std.rst.count",  64'(s_count),  64'(0));
    chk("std.rst.rdata",  64'(s_rdata),  64'(0));
    chk("std.rst.rempty", 64'(s_rempty), 64'(1));
    chk("std.rst.wfull",  64'(s_wfull),  64'(0));
    chk("std.rst.afull",  64'(s_afull),  64'(0));
    chk("std.rst.aempty", 64'(s_aempty), 64'(1));
    chk("std.rst.ovf",    64'(s_ovf),    64'(0));
    chk("std.rst.udf",    64'(s_udf),    64'(0));
    chk("fw.rst.count",   64'(f_count),  64'(0));
    chk("fw.rst.rdata",   64'(f_rdata),  64'(0));
    chk("fw.rst.rempty",  64'(f_rempty), 64'(1));
    chk("fw.rst.wfull",   64'(f_wfull),  64'(0));
    chk("fw.rst.afull",   64'(f_afull),  64'(0));
    chk("fw.rst.aempty",  64'(f_aempty), 64'(1));
    chk("fw.rst.ovf",     64'(f_ovf),    64'(0));
    chk("fw.rst.udf",     64'(f_udf),    64'(0));
  endtask

  // One clock edge with the given inputs, then both models advance and are compared.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bit s_full, s_empty, f_full, f_vis;
    bit exp_so, exp_su, exp_fo, exp_fu;
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
    // Standard mode: plain queue, a read returns the head one cycle later.
    s_full  = (sq.size() == DEPTH);
    s_empty = (sq.size() == 0);
    exp_so  = w && s_full;
    exp_su  = r && s_empty;
    if (r && !s_empty) s_rd_m = sq.pop_front();
    if (w && !s_full) sq.push_back(d);
    // FWFT mode: the head is visible two edges after it was written.
    f_full = (fq.size() == DEPTH);
    f_vis  = (fq.size() != 0) && (fq[0].wr + 2 <= cyc);
    exp_fo = w && f_full;
    exp_fu = r && !f_vis;
    if (r && f_vis) fq.delete(0);
    cyc++;
    if (w && !f_full) fq.push_back('{data: d, wr: cyc});
    f_vis = (fq.size() != 0) && (fq[0].wr + 2 <= cyc);

    chk("std.count",  64'(s_count),  64'(sq.size()));
    chk("std.rdata",  64'(s_rdata),  64'(s_rd_m));
    chk("std.rempty", 64'(s_rempty), 64'(sq.size() == 0));
    chk("std.wfull",  64'(s_wfull),  64'(sq.size() == DEPTH));
    chk("std.afull",  64'(s_afull),  64'(sq.size() >= AF));
    chk("std.aempty", 64'(s_aempty), 64'(sq.size() <= AE));
    chk("std.ovf",    64'(s_ovf),    64'(exp_so));
    chk("std.udf",    64'(s_udf),    64'(exp_su));
    chk("fw.count",   64'(f_count),  64'(fq.size()));
    chk("fw.rempty",  64'(f_rempty), 64'(!f_vis));
    if (f_vis) chk("fw.rdata", 64'(f_rdata), 64'(fq[0].data));
    chk("fw.wfull",   64'(f_wfull),  64'(fq.size() == DEPTH));
    chk("fw.afull",   64'(f_afull),  64'(fq.size() >= AF));
    chk("fw.aempty",  64'(f_aempty), 64'(fq.size() <= AE));
    chk("fw.ovf",     64'(f_ovf),    64'(exp_fo));
    chk("fw.udf",     64'(f_udf),    64'(exp_fu));
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sq.size() == 0 && fq.size() == 0) break;
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    // Reset and idle.
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0);

    // Fill to full plus one rejected write, then drain with one extra read.
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 32'hDEAD_0001, 1'b0);
    step(1'b0, '0, 1'b0);
    repeat (17) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("std.drain_last", 64'(s_rdata), 64'(32'h0F));

    // Simultaneous write+read at full, then at empty.
    for (int i = 0; i < 16; i++) step(1'b1, DW'(100 + i), 1'b0);
    step(1'b1, 32'hBEEF, 1'b1);
    chk("std.full_wr_rd.count", 64'(s_count), 64'(15));
    repeat (2) step(1'b0, '0, 1'b0);
    repeat (16) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b1, 32'h55, 1'b1);
    chk("std.empty_wr_rd.count", 64'(s_count), 64'(1));

    // Hold count at 5 under continuous write+read, wrapping the pointers.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(200 + i), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (40) step(1'b1, $urandom, 1'b1);
    chk("fw.steady5.count", 64'(f_count), 64'(5));
    drain();

    // FWFT write-to-visible latency, then back-to-back streaming.
    step(1'b1, 32'hA5, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("fw.a5.rdata", 64'(f_rdata), 64'(32'hA5));
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    repeat (20) step(1'b1, $urandom, 1'b1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50);
    end
    drain();

    // Asynchronous reset in the middle of a cycle at count 9.
    for (int i = 0; i < 9; i++) step(1'b1, $urandom, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset();
    sq.delete();
    fq.delete();
    s_rd_m = '0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h1234, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    chk("fw.post_rst.rdata", 64'(f_rdata), 64'(32'h1234));
    step(1'b0, '0, 1'b1);
    chk("std.post_rst.rdata", 64'(s_rdata), 64'(32'h1234));
    step(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/syn_fifo_fwft.md
# syn_fifo_fwft

Parametrised single-clock FIFO for the page-level streaming datapath: it buffers DSIZE-bit words between a producer and a consumer sharing one clock. It generalises the existing synchronous FIFO with:
- a selectable read mode: standard registered read, or first-word-fall-through;
- true full depth of 2^ASIZE words;
- an occupancy count and programmable almost-full / almost-empty flags;
- overflow / underflow error pulses.

Storage is inferred as RAM per RAM_TYPE.

## Interface
- DSIZE, 32: data width in bits (≥1).
- ASIZE, 9: address width; DEPTH = 2^ASIZE words (ASIZE ≥ 2).
- RAM_TYPE, "block": ram_style attribute on storage ("auto", "block", "distributed").
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through mode.
- AFULL_THRESH, DEPTH-2: walmost_full asserts when count ≥ this value (1..DEPTH).
- AEMPTY_THRESH, 2: ralmost_empty asserts when count ≤ this value (0..DEPTH-1).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- wfull  out  1  high when count == DEPTH.
- walmost_full  out  1  high when count ≥ AFULL_THRESH.
- rinc  in  1  read request (standard mode) / acknowledge of the presented word (FWFT mode).
- rdata  out  DSIZE  read data.
- rempty  out  1  no word available to read.
- ralmost_empty  out  1  high when count ≤ AEMPTY_THRESH.
- count  out  ASIZE+1  occupancy, range 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
Pointers:
- wptr and rptr are ASIZE+1 bits wide, with the MSB used as the wrap bit.
- Both wrap naturally modulo 2^(ASIZE+1).

Write:
- A write is accepted iff winc && !wfull.
- An accepted write stores wdata at wptr[ASIZE-1:0] and increments wptr.

Read:
- A read is accepted iff rinc && !rempty.
- Read data is taken from storage at rptr[ASIZE-1:0], and rptr increments.

Count:
- The next count is count + (write accepted) − (read accepted).
- Simultaneous accepted write and read leave count unchanged.
- wfull, walmost_full and ralmost_empty are decoded from the count register.

Standard mode (FWFT=0):
- rempty = (count == 0).
- On an accepted read, rdata loads the head word.
- Otherwise rdata holds its last value; it does not change on a rejected or absent read.

FWFT mode (FWFT=1):
- An output register holds the head word; rempty = !output_valid.
- When the output register is empty and storage is non-empty, the FIFO prefetches automatically.
- rinc && !rempty consumes the presented word; the next word is prefetched back-to-back, with no bubble when storage holds data.
- count includes the word held in the output register, so total capacity remains DEPTH.

Boundary conditions:
- Full with winc && rinc: the read is accepted, the write is rejected (overflow pulses), and count becomes DEPTH−1.
- Empty with winc && rinc: the write is accepted, the read is rejected (underflow pulses), and count becomes 1.
- Pointers wrap across DEPTH without data loss. Full/empty are distinguished by count, not by pointer comparison alone.
- overflow is registered (winc && wfull), high for exactly the cycle after the event. underflow is the same for (rinc && rempty).

Reset:
- Asynchronous and effective immediately.
- Reset values: pointers = 0, count = 0, rempty = 1, wfull = 0, walmost_full = 0, ralmost_empty = 1, rdata = 0, overflow = 0, underflow = 0, FWFT output register invalid.
- Storage contents are not reset.
- Reset mid-transfer discards all contents; the first post-reset write behaves as a write to an empty FIFO.

## Timing
- Write to count: count, wfull and the almost flags reflect a write at edge N after edge N.
- Standard mode read: rinc accepted at edge M places the word on rdata after edge M, i.e. valid in cycle M+1, one-cycle latency.
- FWFT write-to-visible: a write at edge N into an empty FIFO makes rempty fall and rdata valid after edge N+2. This covers the synchronous RAM read plus the output register load.
- FWFT steady-state throughput: with storage non-empty, one word per cycle under continuous rinc.
- Storage read is synchronous, so the RAM is inferable as BRAM for RAM_TYPE="block".
- No combinational path from winc or rinc to any output.

## Test plan
Setup for all scenarios: DSIZE=32, ASIZE=4 (DEPTH=16), AFULL_THRESH=14, AEMPTY_THRESH=2.

- Reset then idle → rempty=1, ralmost_empty=1, count=0, wfull=0, rdata=0, no pulses.
- Standard mode fill: write 0x00..0x0F, then one extra write. Required:
  - walmost_full rises when count=14;
  - wfull=1 at count=16;
  - the extra write pulses overflow for one cycle;
  - count stays 16.
- Standard mode drain of that fill → rdata=0x00..0x0F in order, each valid the cycle after its rinc. A 17th rinc pulses underflow and leaves rdata=0x0F.
- Simultaneous events:
  - winc+rinc at full → count 15, overflow=1;
  - winc+rinc at empty → count 1, underflow=1;
  - continuous winc+rinc with count=5 for 40 cycles (wrapping the pointers) → count stays 5 and data stays in order.
- FWFT=1: write 0xA5 into empty FIFO at edge N → rempty=0 and rdata=0xA5 after edge N+2. Then 20 back-to-back writes/reads → one word per cycle, in order.
- Assert rst asynchronously mid-cycle at count=9 → all outputs take their reset values immediately. The next write of 0x1234 reads back 0x1234.
